// File: rtl/alu_mdu_pipe_if.sv
// Operand/result handshake bundle for alu_mdu_pipe.
// The master drives operands and out_ready; the slave is the arithmetic unit.
interface alu_mdu_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [3:0]      alu_control;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    logic            busy;

    modport master (
        output in_valid, operand1, operand2, alu_control, out_ready,
        input  in_ready, out_valid, alu_out, busy
    );

    modport slave (
        input  in_valid, operand1, operand2, alu_control, out_ready,
        output in_ready, out_valid, alu_out, busy
    );
endinterface

// File: rtl/alu_mdu_pipe.sv
// Execute-stage ALU with registered valid/ready result and optional iterative RV32M unit.
// Define ALU_MULDIV_EN to build MUL/DIV/DIVU/REM/REMU; otherwise those codes return 0 in one cycle.
module alu_mdu_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    alu_mdu_pipe_if.slave bus
);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = $clog2(XLEN + 1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSll  = 4'b0011;
    localparam logic [3:0] OpSrl  = 4'b0100;
    localparam logic [3:0] OpSra  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpXor  = 4'b1100;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
`ifdef ALU_MULDIV_EN
        StMul  = 2'd1,
        StDiv  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    state_e          state_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [XLEN-1:0] alu_out_q;

    logic            in_ready;
    logic            accept;
    logic [ShW-1:0]  shamt;
    logic [XLEN-1:0] simple_res;
    logic [XLEN-1:0] ex_res;

    always_comb begin
        shamt      = bus.operand2[ShW-1:0];
        simple_res = '0;
        case (bus.alu_control)
            OpAnd:   simple_res = bus.operand1 & bus.operand2;
            OpOr:    simple_res = bus.operand1 | bus.operand2;
            OpAdd:   simple_res = bus.operand1 + bus.operand2;
            OpSll:   simple_res = bus.operand1 << shamt;
            OpSrl:   simple_res = bus.operand1 >> shamt;
            OpSra:   simple_res = $unsigned($signed(bus.operand1) >>> shamt);
            OpSub:   simple_res = bus.operand1 - bus.operand2;
            OpSlt:   simple_res = {{(XLEN-1){1'b0}},
                                   ($signed(bus.operand1) < $signed(bus.operand2))};
            OpSltu:  simple_res = {{(XLEN-1){1'b0}}, (bus.operand1 < bus.operand2)};
            OpXor:   simple_res = bus.operand1 ^ bus.operand2;
            default: simple_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OpMul  = 4'b1001;
    localparam logic [3:0] OpDiv  = 4'b1011;
    localparam logic [3:0] OpDivu = 4'b1101;
    localparam logic [3:0] OpRem  = 4'b1110;
    localparam logic [3:0] OpRemu = 4'b1111;

    localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CntW-1:0] LastCnt = CntW'(XLEN);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [CntW-1:0]   cnt_q;
    logic              rem_q;
    logic              neg_q;

    logic            op_mul, op_div, op_signed, op_rem;
    logic            div_zero, div_ovf, mdu_iter, neg1, neg2;
    logic [XLEN-1:0] abs1, abs2, special_res, div_res;
    logic [XLEN:0]   mul_sum, rem_shift, div_sub;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        op_mul    = bus.alu_control == OpMul;
        op_div    = (bus.alu_control == OpDiv) || (bus.alu_control == OpDivu) ||
                    (bus.alu_control == OpRem) || (bus.alu_control == OpRemu);
        op_signed = (bus.alu_control == OpDiv) || (bus.alu_control == OpRem);
        op_rem    = (bus.alu_control == OpRem) || (bus.alu_control == OpRemu);
        div_zero  = op_div && (bus.operand2 == '0);
        div_ovf   = op_signed && (bus.operand1 == MostNeg) && (bus.operand2 == '1);
        mdu_iter  = op_mul || (op_div && !div_zero && !div_ovf);
        neg1      = op_signed && bus.operand1[XLEN-1];
        neg2      = op_signed && bus.operand2[XLEN-1];
        abs1      = neg1 ? -bus.operand1 : bus.operand1;
        abs2      = neg2 ? -bus.operand2 : bus.operand2;

        // Divide-by-zero and overflow resolve immediately and bypass the iterator.
        special_res = '0;
        if (div_zero) begin
            special_res = op_rem ? bus.operand1 : '1;
        end else if (div_ovf) begin
            special_res = op_rem ? '0 : MostNeg;
        end
        ex_res = (div_zero || div_ovf) ? special_res : simple_res;

        // Shift-add step: conditionally add multiplicand to the high half, then shift right.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q & {XLEN{acc_q[0]}}};

        // Restoring step: acc holds {partial remainder, dividend bits / quotient bits}.
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        div_sub   = rem_shift - {1'b0, mcand_q};
        div_next  = div_sub[XLEN] ? {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        div_res = rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    end
`else
    assign ex_res = simple_res;
`endif

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            alu_out_q   <= '0;
`ifdef ALU_MULDIV_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            rem_q       <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
`ifdef ALU_MULDIV_EN
                        if (mdu_iter) begin
                            state_q     <= op_mul ? StMul : StDiv;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            cnt_q       <= '0;
                            acc_q       <= {{XLEN{1'b0}}, op_mul ? bus.operand2 : abs1};
                            mcand_q     <= op_mul ? bus.operand1 : abs2;
                            rem_q       <= op_rem;
                            neg_q       <= op_rem ? neg1 : (neg1 ^ neg2);
                        end else
`endif
                        begin
                            alu_out_q   <= ex_res;
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == StDone) && bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_MULDIV_EN
                StMul: begin
                    if (cnt_q == LastCnt) begin
                        alu_out_q   <= acc_q[XLEN-1:0];
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc_q <= {mul_sum, acc_q[XLEN-1:1]};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDiv: begin
                    if (cnt_q == LastCnt) begin
                        alu_out_q   <= neg_q ? -div_res : div_res;
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Directed bench for alu_mdu_pipe with a queue-based result model and literal pins.
// Honours ALU_MULDIV_EN the same way the design does.
module tb_alu_mdu_pipe;
`ifdef ALU_MULDIV_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    alu_mdu_pipe_if #(.XLEN(32)) bus ();

    alu_mdu_pipe #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_val(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a << b[4:0];
            4'h4: return a >> b[4:0];
            4'h5: return $unsigned($signed(a) >>> b[4:0]);
            4'h6: return a - b;
            4'h7: return (sa < sb) ? 32'd1 : 32'd0;
            4'h8: return (a < b) ? 32'd1 : 32'd0;
            4'hC: return a ^ b;
            default: ;
        endcase
        if (!MdEn) return 32'd0;
        case (op)
            4'h9: return a * b;
            4'hB: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : sa / sb;
            4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hE: return (b == 0) ? a : ovf ? 32'd0 : sa % sb;
            4'hF: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!MdEn) return 1;
        if (op == 4'h9) return 33;
        if (op == 4'hD || op == 4'hF) return (b == 0) ? 1 : 33;
        if (op == 4'hB || op == 4'hE)
            return (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        return 1;
    endfunction

    // Result checker: every freshly presented result is popped from the model queue;
    // a result held across an edge without out_ready must stay put.
    logic        stall_cand = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] held_val = '0;

    always @(posedge clk) hold = stall_cand && !bus.out_ready && !flush && !reset;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_cand = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_data", bus.alu_out, held_val);
                check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.alu_out, e.val);
                    check("latency_cycle", cyc, e.due);
                end
            end
            stall_cand = bus.out_valid && !bus.out_ready && !flush;
            held_val   = bus.alu_out;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit pin, input logic [31:0] pin_val, input int pin_lat,
                         output int acc_cyc, output int waited);
        exp_t e;
        int lat;
        e.val = model_val(op, a, b);
        lat   = model_lat(op, a, b);
        if (pin) begin
            check("pin_value", e.val, pin_val);
            check("pin_latency", lat, pin_lat);
        end
        bus.alu_control = op;
        bus.operand1    = a;
        bus.operand2    = b;
        bus.in_valid    = 1'b1;
        waited = 0;
        #1;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        acc_cyc = cyc;
        e.due   = cyc + lat;
        exp_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3, w;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        va = '{32'h8765_4321, 32'hFFFF_FFF9, 32'd12345};
        vb = '{32'h0000_0013, 32'h0000_0003, 32'hFFFF_FF00};

        bus.in_valid    = 1'b0;
        bus.operand1    = '0;
        bus.operand2    = '0;
        bus.alu_control = '0;
        bus.out_ready   = 1'b1;

        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_alu_out", bus.alu_out, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Back-to-back single-cycle ops.
        issue(4'h2, 32'd10, 32'd5, 1'b1, 32'd15, 1, c0, w);
        issue(4'h6, 32'd10, 32'd5, 1'b1, 32'd5, 1, c1, w);
        issue(4'h0, 32'd10, 32'd5, 1'b1, 32'd0, 1, c2, w);
        issue(4'h1, 32'd10, 32'd5, 1'b1, 32'd15, 1, c3, w);
        check("b2b_gap1", c1 - c0, 32'd1);
        check("b2b_gap2", c2 - c1, 32'd1);
        check("b2b_gap3", c3 - c2, 32'd1);
        drain();

        issue(4'h7, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1, c0, w);
        issue(4'h8, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1, c0, w);
        issue(4'h5, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 1, c0, w);
        issue(4'h3, 32'd3, 32'h21, 1'b1, 32'd6, 1, c0, w);
        issue(4'hA, 32'd3, 32'd4, 1'b1, 32'd0, 1, c0, w);
        drain();

        // Multiply: busy and in_ready during iteration.
        issue(4'h9, 32'd7, 32'hFFFF_FFFD, 1'b1, MdEn ? 32'hFFFF_FFEB : 32'd0,
              MdEn ? 33 : 1, c0, w);
        @(negedge clk);
        check("mul_busy_early", {31'd0, bus.busy}, {31'd0, MdEn});
        check("mul_in_ready_early", {31'd0, bus.in_ready}, {31'd0, !MdEn});
        repeat (9) @(negedge clk);
        check("mul_busy_mid", {31'd0, bus.busy}, {31'd0, MdEn});
        repeat (22) @(negedge clk);
        check("mul_busy_late", {31'd0, bus.busy}, {31'd0, MdEn});
        check("mul_in_ready_late", {31'd0, bus.in_ready}, {31'd0, !MdEn});
        drain();

        issue(4'hB, 32'hFFFF_FFF9, 32'd2, 1'b1, MdEn ? 32'hFFFF_FFFD : 32'd0,
              MdEn ? 33 : 1, c0, w);
        drain();
        issue(4'hE, 32'hFFFF_FFF9, 32'd2, 1'b1, MdEn ? 32'hFFFF_FFFF : 32'd0,
              MdEn ? 33 : 1, c0, w);
        drain();
        issue(4'hD, 32'd100, 32'd0, 1'b1, MdEn ? 32'hFFFF_FFFF : 32'd0, 1, c0, w);
        issue(4'hF, 32'd100, 32'd0, 1'b1, MdEn ? 32'd100 : 32'd0, 1, c0, w);
        issue(4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, MdEn ? 32'h8000_0000 : 32'd0, 1, c0, w);
        issue(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, c0, w);
        drain();

        // Backpressure: result held for several cycles, then same-cycle handoff.
        bus.out_ready = 1'b0;
        issue(4'hC, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'hFFFF_FFFF, 1, c0, w);
        repeat (5) @(negedge clk);
        #1;
        bus.out_ready = 1'b1;
        issue(4'h2, 32'd1, 32'd2, 1'b1, 32'd3, 1, c1, w);
        check("handoff_wait", w, 32'd0);
        check("handoff_cycle", c1 - c0, 32'd5);
        drain();

        // Flush during a divide.
        issue(4'hB, 32'd1000, 32'd7, 1'b0, 32'd0, 0, c0, w);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.delete();
        repeat (40) @(negedge clk);
        #1;

        // Asynchronous reset in the middle of a multiply.
        issue(4'h2, 32'd5, 32'd6, 1'b1, 32'd11, 1, c0, w);
        drain();
        issue(4'h9, 32'd9, 32'd9, 1'b1, MdEn ? 32'd81 : 32'd0, MdEn ? 33 : 1, c0, w);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_alu_out", bus.alu_out, 32'd0);
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
        issue(4'h2, 32'd3, 32'd4, 1'b1, 32'd7, 1, c0, w);
        drain();

        // Sweep every encoding over a few operand pairs against the model.
        for (int i = 0; i < 3; i++) begin
            for (int op = 0; op < 16; op++) begin
                issue(4'(op), va[i], vb[i], 1'b0, 32'd0, 0, c0, w);
                drain();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
